dsc_stoch2bin: RTL and testbench

DSC_STOCH2BIN -- requirements
Module: dsc_stoch2bin

---
 rtl/dsc_pkg.sv | 19 +
 rtl/dsc_counter.sv | 31 +++
 rtl/dsc_stoch2bin.sv | 128 ++++++++++++
 tb/tb_dsc_stoch2bin.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared definitions for the stochastic-to-binary converter: FSM state
// encoding and default operand geometry.
package dsc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } dsc_state_e;

    localparam int DSC_NUM_BITS   = 10;
    localparam int DSC_NUM_INPUTS = 2;

    // Window width in bits for a given operand geometry.
    function automatic int dsc_window_bits(input int num_bits, input int num_inputs);
        return num_bits * num_inputs;
    endfunction

endpackage

// File: rtl/dsc_counter.sv
// Free-running up counter with synchronous clear; o_overflow flags the
// increment that wraps the count from all-ones back to zero.
module dsc_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_count;

    // Clear and increment together load 1: the clearing cycle's event is
    // counted as the first event of the new run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= WIDTH'(i_inc);
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_overflow = i_inc && !i_clr && (r_count == {WIDTH{1'b1}});

endmodule

// File: rtl/dsc_stoch2bin.sv
// Counts ones in a 2^W-sample stochastic bitstream window and presents the
// binary result through a valid/ready output held until accepted.
module dsc_stoch2bin
    import dsc_pkg::*;
#(
    parameter int NUM_BITS   = DSC_NUM_BITS,
    parameter int NUM_INPUTS = DSC_NUM_INPUTS,
    parameter int W          = dsc_window_bits(NUM_BITS, NUM_INPUTS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         start,
    input  logic         sn_in,
    input  logic         sn_valid,
    output logic [W-1:0] z,
    output logic         z_valid,
    input  logic         z_ready,
    output logic         busy,
    output logic         sat,
    output logic [1:0]   o_dbg_state,
    output logic [W-1:0] o_dbg_samples
);

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_ACCUM = 2'(ST_ACCUM);
    localparam logic [1:0] S_HOLD  = 2'(ST_HOLD);

    // Output handshake: a result is transferred on any edge where
    // z_valid && z_ready; z/sat/z_valid are frozen until then, and
    // acceptance is honoured even while en is low.

    logic [1:0]   r_state;
    logic [W:0]   r_ones;
    logic [W-1:0] r_z;
    logic         r_z_valid;
    logic         r_sat;

    logic         w_start;
    logic         w_accept;
    logic         w_samp;
    logic         w_clr;
    logic         w_wrap;
    logic [W:0]   w_ones_next;
    logic [W-1:0] w_samples;

    assign w_start  = en && start;
    assign w_accept = r_z_valid && z_ready;
    assign w_samp   = en && sn_valid && (r_state == S_ACCUM);

    always_comb begin
        w_clr = 1'b0;
        case (r_state)
            S_IDLE:  w_clr = w_start;
            S_ACCUM: w_clr = w_start;
            S_HOLD:  w_clr = w_accept && w_start;
            default: w_clr = 1'b0;
        endcase
    end

    dsc_counter #(
        .WIDTH(W)
    ) u_sample_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_clr      (w_clr),
        .i_inc      (w_samp),
        .o_count    (w_samples),
        .o_overflow (w_wrap)
    );

    assign w_ones_next = r_ones + (W+1)'(sn_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ones    <= '0;
            r_z       <= '0;
            r_z_valid <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ones  <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_start) begin
                        r_ones <= w_samp ? (W+1)'(sn_in) : '0;
                    end else if (w_samp) begin
                        r_ones <= w_ones_next;
                        // Final sample of the window: publish the count
                        // including this sample; a full window saturates.
                        if (w_wrap) begin
                            r_z       <= w_ones_next[W] ? {W{1'b1}} : w_ones_next[W-1:0];
                            r_sat     <= w_ones_next[W];
                            r_z_valid <= 1'b1;
                            r_state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_z_valid <= 1'b0;
                        r_sat     <= 1'b0;
                        if (w_start) begin
                            r_ones  <= '0;
                            r_state <= S_ACCUM;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign z             = r_z;
    assign z_valid       = r_z_valid;
    assign sat           = r_sat;
    assign busy          = (r_state == S_ACCUM);
    assign o_dbg_state   = r_state;
    assign o_dbg_samples = w_samples;

endmodule

// File: tb/tb_dsc_stoch2bin.sv
// Directed scenarios with randomized bit placement for dsc_stoch2bin
// (NUM_BITS=4, NUM_INPUTS=2, 256-sample window).
module tb_dsc_stoch2bin;
    import dsc_pkg::*;

    localparam int W   = 8;
    localparam int WIN = 256;

    logic         clk;
    logic         rst;
    logic         en;
    logic         start;
    logic         sn_in;
    logic         sn_valid;
    logic [W-1:0] z;
    logic         z_valid;
    logic         z_ready;
    logic         busy;
    logic         sat;
    logic [1:0]   dbg_state;
    logic [W-1:0] dbg_samples;

    int n_checks = 0;
    int n_errors = 0;
    bit pat[WIN];

    dsc_stoch2bin #(
        .NUM_BITS   (4),
        .NUM_INPUTS (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .start         (start),
        .sn_in         (sn_in),
        .sn_valid      (sn_valid),
        .z             (z),
        .z_valid       (z_valid),
        .z_ready       (z_ready),
        .busy          (busy),
        .sat           (sat),
        .o_dbg_state   (dbg_state),
        .o_dbg_samples (dbg_samples)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the edge.
    task automatic step(input bit e, input bit v, input bit d, input bit s, input bit r);
        en = e; sn_valid = v; sn_in = d; start = s; z_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Fill pat with exactly n ones at random positions.
    task automatic make_pattern(input int n);
        bit t;
        int j;
        for (int i = 0; i < WIN; i++) pat[i] = (i < n);
        for (int i = WIN - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = pat[i]; pat[i] = pat[j]; pat[j] = t;
        end
    endtask

    function automatic int pat_ones();
        int s = 0;
        for (int i = 0; i < WIN; i++) s += int'(pat[i]);
        return s;
    endfunction

    // Reference result: number of ones in the window, clipped to W bits.
    function automatic int ref_z(input int ones);
        return (ones >= WIN) ? WIN - 1 : ones;
    endfunction

    function automatic int ref_sat(input int ones);
        return (ones == WIN) ? 1 : 0;
    endfunction

    initial begin
        int exp_ones;
        int qi;
        int cyc;
        bit dropped;
        bit seen_valid;
        logic [W-1:0] held_z;

        rst = 1'b1; en = 1'b0; start = 1'b0; sn_in = 1'b0; sn_valid = 1'b0; z_ready = 1'b0;
        step(0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        check("rst_z", z, 0);
        check("rst_zvalid", z_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;

        // 15 ones then 241 zeros, consumer always ready.
        step(1, 0, 0, 1, 1);
        check("s1_busy_start", busy, 1);
        for (int i = 0; i < WIN; i++) begin
            step(1, 1, (i < 15), 0, 1);
            if (i == 99) check("s1_busy_mid", busy, 1);
            if (i == WIN - 2) check("s1_no_early_valid", z_valid, 0);
        end
        check("s1_zvalid", z_valid, 1);
        check("s1_z", z, ref_z(15));
        check("s1_sat", sat, ref_sat(15));
        check("s1_busy_hold", busy, 0);
        step(1, 0, 0, 0, 1);
        check("s1_zvalid_drop", z_valid, 0);
        check("s1_state_idle", dbg_state, ST_IDLE);
        check("s1_z_retained", z, ref_z(15));

        // Full window of ones saturates; acceptance with en low.
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < WIN; i++) step(1, 1, 1, 0, 0);
        check("s2_zvalid", z_valid, 1);
        check("s2_z", z, ref_z(WIN));
        check("s2_sat", sat, ref_sat(WIN));
        step(0, 0, 0, 0, 1);
        check("s2_accept_en0", z_valid, 0);
        check("s2_state_idle", dbg_state, ST_IDLE);

        // 50% sn_valid, en dropped 10 cycles mid-window, 100 ones.
        make_pattern(100);
        exp_ones = pat_ones();
        step(1, 0, 0, 1, 0);
        qi = 0; cyc = 0; dropped = 0;
        while (qi < WIN) begin
            if (qi == 128 && !dropped) begin
                dropped = 1;
                for (int k = 0; k < 10; k++) step(0, 1, 1, 0, 0);
                check("s3_en0_samples", dbg_samples, 128);
                check("s3_en0_busy", busy, 1);
            end
            if (cyc % 2 == 1) begin
                step(1, 1, pat[qi], 0, 0);
                qi++;
                if (qi == WIN - 1) check("s3_not_done_255", z_valid, 0);
            end else begin
                step(1, 0, 1'($urandom_range(0, 1)), 0, 0);
            end
            cyc++;
        end
        check("s3_zvalid", z_valid, 1);
        check("s3_z", z, ref_z(exp_ones));
        check("s3_sat", sat, ref_sat(exp_ones));

        // Restart mid-window: the start-cycle sample is sample 0.
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 100; i++) step(1, 1, 1, 0, 0);
        check("s4_partial", dbg_samples, 100);
        make_pattern(40);
        exp_ones = pat_ones();
        step(1, 1, pat[0], 1, 0);
        check("s4_restart_cnt", dbg_samples, 1);
        for (int i = 1; i < WIN; i++) step(1, 1, pat[i], 0, 0);
        check("s4_zvalid", z_valid, 1);
        check("s4_z", z, ref_z(exp_ones));

        // Hold 20 cycles with traffic and ignored starts.
        held_z = z;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 1, (i == 5 || i == 12), 0);
            check("s5_hold_zvalid", z_valid, 1);
            check("s5_hold_z", z, ref_z(exp_ones));
            check("s5_hold_busy", busy, 0);
        end
        check("s5_z_unchanged", z, held_z);
        step(1, 0, 0, 1, 1);
        check("s5_accept_start_busy", busy, 1);
        check("s5_accept_start_zvalid", z_valid, 0);
        check("s5_accept_start_state", dbg_state, ST_ACCUM);
        check("s5_cnt_cleared", dbg_samples, 0);

        // Reset mid-window (with start asserted) discards everything.
        for (int i = 0; i < 128; i++) step(1, 1, 1'($urandom_range(0, 1)), 0, 0);
        check("s6_pre_rst_cnt", dbg_samples, 128);
        rst = 1'b1;
        step(1, 1, 1, 1, 0);
        rst = 1'b0;
        check("s6_rst_z", z, 0);
        check("s6_rst_zvalid", z_valid, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_sat", sat, 0);
        check("s6_rst_state", dbg_state, ST_IDLE);
        check("s6_rst_cnt", dbg_samples, 0);
        seen_valid = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 1, 1'($urandom_range(0, 1)), 0, 1);
            if (z_valid) seen_valid = 1;
        end
        check("s6_no_valid_without_start", seen_valid, 0);
        make_pattern($urandom_range(0, WIN));
        exp_ones = pat_ones();
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < WIN; i++) step(1, 1, pat[i], 0, 0);
        check("s6_zvalid", z_valid, 1);
        check("s6_z", z, ref_z(exp_ones));
        check("s6_sat", sat, ref_sat(exp_ones));
        step(1, 0, 0, 0, 1);
        check("s6_final_drop", z_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
